// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/exec) arbiter for one shared memory port, with an optional watchdog.
// Define ARB_ROUND_ROBIN_EN for fair arbitration; otherwise exec has fixed priority over fetch.
module mem_port_arbiter #(
  parameter int M_WIDTH  = 8,
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_req,
  input  logic               f_we,
  input  logic [M_WIDTH-1:0] f_addr,
  input  logic [M_WIDTH-1:0] f_wdata,
  input  logic [1:0]         f_acc_width,
  output logic [M_WIDTH-1:0] f_rdata,
  output logic               f_ready,
  output logic               f_err,
  input  logic               e_req,
  input  logic               e_we,
  input  logic [M_WIDTH-1:0] e_addr,
  input  logic [M_WIDTH-1:0] e_wdata,
  input  logic [1:0]         e_acc_width,
  output logic [M_WIDTH-1:0] e_rdata,
  output logic               e_ready,
  output logic               e_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [M_WIDTH-1:0] mem_addr,
  output logic [M_WIDTH-1:0] mem_data_out,
  output logic [1:0]         mem_acc_width,
  input  logic [M_WIDTH-1:0] mem_data_in,
  input  logic               mem_ready,
  output logic [1:0]         grant,
  output logic               busy
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_GRANTED = 1'b1
  } state_t;

  localparam logic [1:0] MEM_ACC_32 = 2'b10;
  localparam bit         WD_EN      = (TIMEOUT > 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST = (TIMEOUT > 0) ? TO_WIDTH'(TIMEOUT - 1) : '0;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [TO_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

  logic               own_e;
  logic               own_req;
  logic               own_we;
  logic [M_WIDTH-1:0] own_addr;
  logic [M_WIDTH-1:0] own_wdata;
  logic [1:0]         own_acc;
  logic               done;
  logic               timeout;
  logic               prio_e;
  logic               pick_e;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers whether exec won the most recent grant; a tie goes to the other port.
  logic last_e_q, last_e_d;
  assign prio_e = ~last_e_q;
`else
  assign prio_e = 1'b1;
`endif

  always_comb begin
    own_e     = grant_q[1];
    own_req   = own_e ? e_req       : f_req;
    own_we    = own_e ? e_we        : f_we;
    own_addr  = own_e ? e_addr      : f_addr;
    own_wdata = own_e ? e_wdata     : f_wdata;
    own_acc   = own_e ? e_acc_width : f_acc_width;
    done      = (state_q == S_GRANTED) && own_req && mem_ready;
    // A real mem_ready in the last allowed cycle beats the watchdog.
    timeout   = WD_EN && (state_q == S_GRANTED) && own_req && !mem_ready &&
                (wd_cnt_q == TO_LAST);
    pick_e    = e_req && (!f_req || prio_e);
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_data_out  = '0;
    mem_acc_width = MEM_ACC_32;
    f_rdata       = '0;
    f_ready       = 1'b0;
    f_err         = 1'b0;
    e_rdata       = '0;
    e_ready       = 1'b0;
    e_err         = 1'b0;
    grant         = grant_q;
    busy          = (state_q == S_GRANTED);
    if (state_q == S_GRANTED) begin
      mem_req       = own_req && !timeout;
      mem_we        = own_we;
      mem_addr      = own_addr;
      mem_data_out  = own_wdata;
      mem_acc_width = own_acc;
      if (own_e) begin
        e_rdata = timeout ? '0 : mem_data_in;
        e_ready = done || timeout;
        e_err   = timeout;
      end else begin
        f_rdata = timeout ? '0 : mem_data_in;
        f_ready = done || timeout;
        f_err   = timeout;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    wd_cnt_d = wd_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_e_d = last_e_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (f_req || e_req) begin
          state_d  = S_GRANTED;
          grant_d  = {pick_e, !pick_e};
          wd_cnt_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_e_d = pick_e;
`endif
        end
      end
      S_GRANTED: begin
        // Abort (owner dropped req), completion and timeout all release the port.
        if (!own_req || done || timeout) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end else begin
          wd_cnt_d = wd_cnt_q + TO_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'b00;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_e_q <= 1'b0;
    else     last_e_q <= last_e_d;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 4;

  logic       clk, rst;
  logic       f_req, f_we, e_req, e_we, mem_ready;
  logic [7:0] f_addr, f_wdata, e_addr, e_wdata, mem_data_in;
  logic [1:0] f_acc_width, e_acc_width;
  logic [7:0] f_rdata, e_rdata, mem_addr, mem_data_out;
  logic       f_ready, f_err, e_ready, e_err, mem_req, mem_we, busy;
  logic [1:0] mem_acc_width, grant;

  mem_port_arbiter #(.M_WIDTH(8), .TIMEOUT(TIMEOUT), .TO_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata), .f_acc_width(f_acc_width),
    .f_rdata(f_rdata), .f_ready(f_ready), .f_err(f_err),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata), .e_acc_width(e_acc_width),
    .e_rdata(e_rdata), .e_ready(e_ready), .e_err(e_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_acc_width(mem_acc_width), .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the port (-1 none, 0 F, 1 E), cycles spent owning it, last winner.
  int m_owner, m_age, m_last;
  logic m_release;
  logic       x_mem_req, x_mem_we, x_f_ready, x_f_err, x_e_ready, x_e_err, x_busy;
  logic [7:0] x_mem_addr, x_mem_data_out, x_f_rdata, x_e_rdata;
  logic [1:0] x_mem_acc_width, x_grant;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_last = 0;
  endtask

  task automatic model_eval();
    logic oreq, tmo, done;
    x_mem_req = 0; x_mem_we = 0; x_mem_addr = 0; x_mem_data_out = 0; x_mem_acc_width = 2'b10;
    x_f_ready = 0; x_f_err = 0; x_f_rdata = 0; x_e_ready = 0; x_e_err = 0; x_e_rdata = 0;
    x_grant = 0; x_busy = 0; m_release = 0;
    if (m_owner >= 0) begin
      oreq = (m_owner == 1) ? e_req : f_req;
      tmo  = (TIMEOUT > 0) && oreq && !mem_ready && (m_age == TIMEOUT - 1);
      done = oreq && mem_ready;
      m_release       = !oreq || done || tmo;
      x_busy          = 1;
      x_grant         = (m_owner == 1) ? 2'b10 : 2'b01;
      x_mem_req       = oreq && !tmo;
      x_mem_we        = (m_owner == 1) ? e_we : f_we;
      x_mem_addr      = (m_owner == 1) ? e_addr : f_addr;
      x_mem_data_out  = (m_owner == 1) ? e_wdata : f_wdata;
      x_mem_acc_width = (m_owner == 1) ? e_acc_width : f_acc_width;
      if (m_owner == 1) begin
        x_e_ready = done || tmo; x_e_err = tmo; x_e_rdata = tmo ? 8'h00 : mem_data_in;
      end else begin
        x_f_ready = done || tmo; x_f_err = tmo; x_f_rdata = tmo ? 8'h00 : mem_data_in;
      end
    end
  endtask

  // Clock edge as seen by the model; inputs are still the ones that were compared.
  task automatic model_edge();
    int pick;
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (f_req || e_req) begin
        if (f_req && e_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick = (m_last == 1) ? 0 : 1;
`else
          pick = 1;
`endif
        end else begin
          pick = e_req ? 1 : 0;
        end
        m_owner = pick; m_age = 0; m_last = pick;
      end
    end else if (m_release) begin
      m_owner = -1;
    end else begin
      m_age++;
    end
  endtask

  // Compare every output against the model at the negedge.
  task automatic settle();
    @(negedge clk);
    model_eval();
    chk("mem_req", mem_req, x_mem_req);
    chk("mem_we", mem_we, x_mem_we);
    chk("mem_addr", mem_addr, x_mem_addr);
    chk("mem_data_out", mem_data_out, x_mem_data_out);
    chk("mem_acc_width", mem_acc_width, x_mem_acc_width);
    chk("f_ready", f_ready, x_f_ready);
    chk("f_err", f_err, x_f_err);
    chk("f_rdata", f_rdata, x_f_rdata);
    chk("e_ready", e_ready, x_e_ready);
    chk("e_err", e_err, x_e_err);
    chk("e_rdata", e_rdata, x_e_rdata);
    chk("grant", grant, x_grant);
    chk("busy", busy, x_busy);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic next_req(input logic cur, input logic rdy);
    if (cur) begin
      if (rdy) return ($urandom_range(3) == 0);
      return ($urandom_range(19) != 0);
    end
    return ($urandom_range(2) == 0);
  endfunction

  logic [1:0] exp_order [4];
  logic nf, ne;

  initial begin
    model_reset();
    rst = 1; f_req = 0; f_we = 0; f_addr = 0; f_wdata = 0; f_acc_width = 2'b10;
    e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_acc_width = 2'b10;
    mem_ready = 0; mem_data_in = 0;
    settle();
    chk("rst_grant", grant, 2'b00);
    chk("rst_acc_width", mem_acc_width, 2'b10);
    chk("rst_busy", busy, 1'b0);
    advance();
    rst = 0;

    // Fetch read, memory answers in the third granted cycle
    f_req = 1; f_addr = 8'h10; f_we = 0;
    settle(); advance();
    settle();
    chk("fr_grant", grant, 2'b01);
    chk("fr_addr", mem_addr, 8'h10);
    chk("fr_we", mem_we, 1'b0);
    chk("fr_req", mem_req, 1'b1);
    advance(); settle(); advance();
    mem_ready = 1; mem_data_in = 8'hA5;
    settle();
    chk("fr_ready", f_ready, 1'b1);
    chk("fr_rdata", f_rdata, 8'hA5);
    chk("fr_e_ready", e_ready, 1'b0);
    advance();
    mem_ready = 0; f_req = 0;
    settle();
    chk("fr_idle", grant, 2'b00);
    advance();

    // Simultaneous requests: exec first, fetch after one idle cycle
    f_req = 1; f_addr = 8'h11; e_req = 1; e_we = 1; e_addr = 8'h20; e_wdata = 8'h3C;
    settle(); advance();
    mem_ready = 1; mem_data_in = 8'h99;
    settle();
    chk("sim_grant_e", grant, 2'b10);
    chk("sim_we", mem_we, 1'b1);
    chk("sim_wdata", mem_data_out, 8'h3C);
    chk("sim_e_ready", e_ready, 1'b1);
    chk("sim_f_ready", f_ready, 1'b0);
    advance();
    e_req = 0; e_we = 0; mem_ready = 0;
    settle();
    chk("sim_idle", grant, 2'b00);
    advance();
    mem_ready = 1; mem_data_in = 8'h42;
    settle();
    chk("sim_grant_f", grant, 2'b01);
    chk("sim_f_addr", mem_addr, 8'h11);
    chk("sim_f_rdata", f_rdata, 8'h42);
    advance();
    f_req = 0; mem_ready = 0;

    // Watchdog on exec with a silent memory
    e_req = 1; e_addr = 8'h30; mem_data_in = 8'h77;
    settle(); advance();
    for (int i = 1; i <= 3; i++) begin
      settle();
      chk("wd_wait_ready", e_ready, 1'b0);
      advance();
    end
    settle();
    chk("wd_ready", e_ready, 1'b1);
    chk("wd_err", e_err, 1'b1);
    chk("wd_req", mem_req, 1'b0);
    chk("wd_rdata", e_rdata, 8'h00);
    advance();
    e_req = 0;
    settle();
    chk("wd_idle", grant, 2'b00);
    advance();

    // Abort: fetch drops req in its third granted cycle while memory answers
    f_req = 1; f_addr = 8'h40;
    settle(); advance();
    settle(); advance();
    settle(); advance();
    f_req = 0; mem_ready = 1;
    settle();
    chk("ab_req", mem_req, 1'b0);
    chk("ab_ready", f_ready, 1'b0);
    chk("ab_busy", busy, 1'b1);
    advance();
    mem_ready = 0;
    settle();
    chk("ab_idle", grant, 2'b00);
    advance();

    // Asynchronous reset in the middle of an exec transaction
    e_req = 1; e_addr = 8'h50;
    settle(); advance();
    settle();
    chk("ar_grant", grant, 2'b10);
    #1 rst = 1;
    #1;
    chk("ar_req", mem_req, 1'b0);
    chk("ar_grant0", grant, 2'b00);
    chk("ar_busy", busy, 1'b0);
    model_reset();
    rst = 0;
    advance();
    mem_ready = 1; mem_data_in = 8'h5A;
    settle();
    chk("ar_e_ready", e_ready, 1'b1);
    chk("ar_e_rdata", e_rdata, 8'h5A);
    advance();
    e_req = 0; mem_ready = 0;

    // Grant order with both requesters holding req, starting from reset
    rst = 1;
    #1 model_reset();
    advance();
    rst = 0; f_req = 1; e_req = 1; mem_ready = 1;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_order = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    for (int i = 0; i < 4; i++) begin
      settle(); advance();
      settle();
      chk("order_grant", grant, exp_order[i]);
      advance();
    end
    f_req = 0; e_req = 0; mem_ready = 0;
    settle(); advance();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      nf = next_req(f_req, x_f_ready);
      ne = next_req(e_req, x_e_ready);
      if (!(nf && f_req && !x_f_ready)) begin
        f_we = $urandom_range(3) == 0; f_addr = 8'($urandom); f_wdata = 8'($urandom);
        f_acc_width = 2'($urandom_range(2));
      end
      if (!(ne && e_req && !x_e_ready)) begin
        e_we = $urandom_range(1) == 0; e_addr = 8'($urandom); e_wdata = 8'($urandom);
        e_acc_width = 2'($urandom_range(2));
      end
      f_req = nf; e_req = ne;
      mem_ready = ($urandom_range(3) == 0);
      mem_data_in = 8'($urandom);
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data/instruction memory port between two requesters: instruction fetch (port F, index 0) and the execute stage load/store path (port E, index 1).
- Sits between the fetch and exec blocks and the memory model or controller. It uses the same mem_req/mem_ready handshake and MEM_ACC_* width encoding on both sides.
- Registers the grant, muxes address, data and control to memory, and routes data and completion back to the granted requester only.
- Includes a watchdog so a dead memory cannot hang the core.

Parameters:
- M_WIDTH, 8, address and data width.
- TIMEOUT, 255, max cycles to wait for mem_ready once granted; 0 disables the watchdog.
- TO_WIDTH, 8, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch request; held until f_ready
- f_we  in  1  fetch write enable (normally 0)
- f_addr  in  M_WIDTH  fetch address
- f_wdata  in  M_WIDTH  fetch write data
- f_acc_width  in  2  fetch access width (MEM_ACC_8/16/32 = 00/01/10)
- f_rdata  out  M_WIDTH  read data to fetch
- f_ready  out  1  one-cycle completion pulse to fetch
- f_err  out  1  one-cycle timeout pulse to fetch, coincident with f_ready
- e_req, e_we, e_addr, e_wdata, e_acc_width, e_rdata, e_ready, e_err: same widths and meaning as the f_ ports, for exec
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  M_WIDTH  address to memory
- mem_data_out  out  M_WIDTH  write data to memory
- mem_acc_width  out  2  access width to memory
- mem_data_in  in  M_WIDTH  read data from memory
- mem_ready  in  1  memory completion; one-cycle pulse
- grant  out  2  one-hot owner, {E,F}; 00 when idle
- busy  out  1  high in GRANTED state

Behaviour:
- Reset (asynchronous, rst=1): state IDLE, grant=00, watchdog count 0, round-robin pointer = F.
  - All outputs are 0 during reset; mem_acc_width is 2'b10 (MEM_ACC_32).
- States:
  - IDLE: mem_req=0; memory-side outputs are 0, except mem_acc_width=MEM_ACC_32.
  - On a clock edge with any req high, latch a one-hot grant and go to GRANTED.
  - Arbitration (default): E has fixed priority over F. Simultaneous requests grant E.
  - GRANTED: memory-side outputs are combinationally muxed from the granted port. mem_req = granted port's req.
  - The granted port's rdata = mem_data_in. The other port's rdata = 0 and its ready = 0.
- Completion: mem_ready=1 while GRANTED and the owner's req is high:
  - owner's ready=1 in that same cycle (combinational);
  - next edge goes to IDLE and clears grant.
- Latency: req high in cycle N (IDLE) -> mem_req in N+1. At least one IDLE cycle separates back-to-back transactions.
- Requester rule: drop req in the cycle after its ready pulse. A req still high in IDLE is treated as a new request.
- Abort: owner drops req while GRANTED -> mem_req drops that cycle, no ready is issued, next edge goes to IDLE. A mem_ready in the abort cycle is ignored.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to GRANTED and increments each GRANTED cycle without mem_ready.
  - When the count reaches TIMEOUT-1 with no mem_ready: owner's ready=1 and err=1, rdata=0, mem_req forced 0 that cycle, next edge goes to IDLE.
  - mem_ready in that same cycle wins: normal completion, err=0.
- Non-owner inputs are ignored while GRANTED; changes on them have no effect on the memory side.
- Write data and width pass through unmodified. The arbiter performs no alignment or masking.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: fair arbitration. On a simultaneous request, the port not granted last wins.
  - The pointer updates on every grant to the other port.
  - A single requester is always granted regardless of the pointer.
- Undefined: fixed E-over-F priority; no pointer register exists.

Test Plan:
- Reset then F read: f_req=1, f_addr=0x10, memory returns 0xA5 after 3 cycles -> grant=01 one cycle after req; mem_addr=0x10, mem_we=0; f_ready and f_rdata=0xA5 coincide with mem_ready; e_ready=0; IDLE next cycle.
- Simultaneous: f_req=e_req=1 in the same cycle, e_we=1, e_addr=0x20, e_wdata=0x3C -> E granted first (mem_we=1, mem_data_out=0x3C). After e_ready and one IDLE cycle, F granted.
- With ARB_ROUND_ROBIN_EN: both requesters hold req for 4 transactions -> grant order E,F,E,F. Without the macro and with e_req re-raised after each completion -> E,E,E,E.
- Watchdog: TIMEOUT=4, E granted, mem_ready never asserted -> e_ready=e_err=1 on the 4th GRANTED cycle; mem_req=0 that cycle; grant=00 next cycle.
- Abort: F granted, f_req dropped after 2 cycles, mem_ready pulses the same cycle -> mem_req=0 immediately, f_ready=0, IDLE next edge.
- Async reset mid-transaction: rst pulsed between clock edges while GRANTED -> mem_req, grant and busy go to 0 immediately without a clock edge; after release, a fresh e_req is served normally.
